// File: rtl/fadd_share_arbiter.sv
// Round-robin arbiter that time-shares one floating-point adder among N_REQ requesters.
// Optional statistics counters are enabled with `define FADD_ARB_STATS_EN.
module fadd_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_stb,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_result,
    input  logic [N_REQ-1:0]      rsp_ack,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy,
    output logic                  adder_load,
    output logic [31:0]           adder_a,
    output logic [31:0]           adder_b,
    input  logic                  adder_ready,
    input  logic [31:0]           adder_result,
`ifdef FADD_ARB_STATS_EN
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_wait_cycles,
`endif
    output logic                  adder_ack
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DELIVER,
        S_RELEASE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_nxt;
    logic [N_REQ-1:0]   r_rsp_ready, w_rsp_ready_nxt;
    logic [31:0]        r_rsp_result, w_rsp_result_nxt;
    logic [31:0]        r_adder_a, w_adder_a_nxt;
    logic [31:0]        r_adder_b, w_adder_b_nxt;
    logic               r_adder_load, w_adder_load_nxt;
    logic               r_adder_ack, w_adder_ack_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_found;
    logic [SEL_W-1:0]   w_k;
    logic [SEL_W-1:0]   w_grant_sel;
    logic [SEL_W-1:0]   w_gsel;
    logic [31:0]        w_sel_a, w_sel_b;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_ack_hit;

    assign w_gsel    = SEL_W'(r_grant_idx);
    assign w_ack_hit = rsp_ack[w_gsel];

    // First pending requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found     = 1'b0;
        w_grant_sel = '0;
        w_k         = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_k = SEL_W'((32'(r_rr_ptr) + i) % N_REQ);
            if (!w_found && req_stb[w_k]) begin
                w_found     = 1'b1;
                w_grant_sel = w_k;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (SEL_W'(i) == w_grant_sel) begin
                w_sel_a = req_a[i*32 +: 32];
                w_sel_b = req_b[i*32 +: 32];
            end
        end
    end

    // State and all output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant_idx  <= '0;
            r_rsp_ready  <= '0;
            r_rsp_result <= '0;
            r_adder_a    <= '0;
            r_adder_b    <= '0;
            r_adder_load <= 1'b0;
            r_adder_ack  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_grant_idx  <= w_grant_idx_nxt;
            r_rsp_ready  <= w_rsp_ready_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_adder_a    <= w_adder_a_nxt;
            r_adder_b    <= w_adder_b_nxt;
            r_adder_load <= w_adder_load_nxt;
            r_adder_ack  <= w_adder_ack_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found)      w_state_nxt = S_WAIT;
            S_WAIT:    if (adder_ready)  w_state_nxt = S_DELIVER;
            S_DELIVER: if (w_ack_hit)    w_state_nxt = S_RELEASE;
            // Wait for the adder to drop ready so a stale result is never re-read.
            S_RELEASE: if (!adder_ready) w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rr_ptr_nxt     = r_rr_ptr;
        w_grant_idx_nxt  = r_grant_idx;
        w_rsp_ready_nxt  = r_rsp_ready;
        w_rsp_result_nxt = r_rsp_result;
        w_adder_a_nxt    = r_adder_a;
        w_adder_b_nxt    = r_adder_b;
        w_adder_load_nxt = 1'b0;
        w_adder_ack_nxt  = r_adder_ack;
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_onehot         = '0;
        w_onehot[w_gsel] = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_idx_nxt  = IDX_W'(w_grant_sel);
                    w_adder_a_nxt    = w_sel_a;
                    w_adder_b_nxt    = w_sel_b;
                    w_adder_load_nxt = 1'b1;
                    w_rr_ptr_nxt     = (w_grant_sel == SEL_W'(N_REQ - 1)) ?
                                       '0 : IDX_W'(w_grant_sel) + IDX_W'(1);
                end
            end
            S_WAIT: begin
                if (adder_ready) begin
                    w_rsp_result_nxt = adder_result;
                    w_rsp_ready_nxt  = w_onehot;
                    w_adder_ack_nxt  = 1'b1;
                end
            end
            S_DELIVER: begin
                if (w_ack_hit) begin
                    w_rsp_ready_nxt = '0;
                    w_adder_ack_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign rsp_ready  = r_rsp_ready;
    assign rsp_result = r_rsp_result;
    assign grant_idx  = r_grant_idx;
    assign busy       = r_busy;
    assign adder_load = r_adder_load;
    assign adder_a    = r_adder_a;
    assign adder_b    = r_adder_b;
    assign adder_ack  = r_adder_ack;

`ifdef FADD_ARB_STATS_EN
    logic [31:0] r_stat_grants, r_stat_wait_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_grants      <= '0;
            r_stat_wait_cycles <= '0;
        end else begin
            if (r_state == S_DELIVER && w_ack_hit)
                r_stat_grants <= r_stat_grants + 32'd1;
            if (r_state == S_WAIT)
                r_stat_wait_cycles <= r_stat_wait_cycles + 32'd1;
        end
    end

    assign stat_grants      = r_stat_grants;
    assign stat_wait_cycles = r_stat_wait_cycles;
`endif

endmodule

// File: tb/tb_fadd_share_arbiter.sv
// Directed bench for fadd_share_arbiter with a behavioural adder model.
// Define FADD_ARB_STATS_EN to also check the statistics counters.
module tb_fadd_share_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_stb, rsp_ack, rsp_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  rsp_result, adder_a, adder_b, adder_result;
    logic [1:0]   grant_idx;
    logic         busy, adder_load, adder_ready, adder_ack;
`ifdef FADD_ARB_STATS_EN
    logic [31:0]  stat_grants, stat_wait_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int m_lat  = 3;
    int m_hold = 0;

    always #5 clk = ~clk;

    fadd_share_arbiter #(.N_REQ(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_stb(req_stb), .req_a(req_a), .req_b(req_b),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_ack(rsp_ack),
        .grant_idx(grant_idx), .busy(busy),
        .adder_load(adder_load), .adder_a(adder_a), .adder_b(adder_b),
        .adder_ready(adder_ready), .adder_result(adder_result),
`ifdef FADD_ARB_STATS_EN
        .stat_grants(stat_grants), .stat_wait_cycles(stat_wait_cycles),
`endif
        .adder_ack(adder_ack)
    );

    // Adder model: ready rises m_lat edges after it sees load, and stays up
    // for m_hold further cycles after it first sees result_ack.
    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    logic [31:0] m_res;
    int          m_cnt, m_hcnt;
    bit          m_hact;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            adder_ready  <= 1'b0;
            adder_result <= '0;
            m_res        <= '0;
            m_cnt        <= 0;
            m_hcnt       <= 0;
            m_hact       <= 1'b0;
        end else begin
            if (adder_load) begin
                m_cnt <= m_lat - 1;
                m_res <= model_sum(adder_a, adder_b);
            end else if (m_cnt != 0) begin
                if (m_cnt == 1) begin
                    adder_ready  <= 1'b1;
                    adder_result <= m_res;
                end
                m_cnt <= m_cnt - 1;
            end
            if (m_hact) begin
                if (m_hcnt == 0) begin
                    adder_ready <= 1'b0;
                    m_hact      <= 1'b0;
                end else begin
                    m_hcnt <= m_hcnt - 1;
                end
            end else if (adder_ready && adder_ack) begin
                if (m_hold == 0) adder_ready <= 1'b0;
                else begin
                    m_hact <= 1'b1;
                    m_hcnt <= m_hold - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (adder_load) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Runs one grant-to-ack transaction and returns what was observed.
    task automatic do_txn(input logic [3:0] clr, output bit ok, output logic [1:0] g,
                          output int lw, output logic [3:0] rdy, output logic [31:0] res);
        bit ok2;
        wait_load(ok);
        g  = grant_idx;
        lw = 0;
        while (adder_load && lw < 10) begin
            lw++;
            tick();
        end
        ok2 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_ready != '0) begin
                ok2 = 1'b1;
                break;
            end
            tick();
        end
        ok  = ok && ok2;
        rdy = rsp_ready;
        res = rsp_result;
        rsp_ack = rsp_ready;
        req_stb = req_stb & ~clr;
        tick();
        rsp_ack = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_stb = '0; rsp_ack = '0; req_a = '0; req_b = '0;
        tick(); tick();
        checks++;
        if ({rsp_ready, rsp_result, adder_load, adder_ack, adder_a, adder_b, grant_idx, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b res=%h load=%b ack=%b a=%h b=%h g=%0d busy=%b, required all 0",
                     rsp_ready, rsp_result, adder_load, adder_ack, adder_a, adder_b, grant_idx, busy);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_stb = 4'b0001;
        tick();
        checks++;
        if ({adder_load, grant_idx, busy} !== 4'b1001 || adder_a !== 32'h3F800000 || adder_b !== 32'h40000000) begin
            errors++;
            $display("FAIL single_grant: load=%b g=%0d busy=%b a=%h b=%h, required 1 0 1 3f800000 40000000",
                     adder_load, grant_idx, busy, adder_a, adder_b);
        end
        tick();
        checks++;
        if (adder_load !== 1'b0) begin
            errors++;
            $display("FAIL single_load_pulse: load=%b, required 0", adder_load);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_ready != '0) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok || rsp_ready !== 4'b0001 || rsp_result !== 32'h40400000 || adder_ack !== 1'b1) begin
            errors++;
            $display("FAIL single_result: seen=%b rdy=%b res=%h ack=%b, required 1 0001 40400000 1",
                     ok, rsp_ready, rsp_result, adder_ack);
        end
        rsp_ack = 4'b0001;
        req_stb = '0;
        tick();
        rsp_ack = '0;
        checks++;
        if (rsp_ready !== 4'b0000 || adder_ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_release: rdy=%b ack=%b busy=%b, required 0000 0 1", rsp_ready, adder_ack, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rsp_result !== 32'h40400000) begin
            errors++;
            $display("FAIL single_idle: busy=%b res=%h, required 0 40400000", busy, rsp_result);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_res [4] = '{32'h101, 32'h202, 32'h303, 32'h404};
        bit ok; logic [1:0] g; int lw; logic [3:0] rdy; logic [31:0] res;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'h100 * (i + 1);
            req_b[i*32 +: 32] = 32'(i + 1);
        end
        req_stb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            do_txn(4'(1 << i), ok, g, lw, rdy, res);
            checks++;
            if (!ok || g !== 2'(i) || lw !== 1 || rdy !== 4'(1 << i) || res !== exp_res[i]) begin
                errors++;
                $display("FAIL rr_txn%0d: ok=%b g=%0d loadw=%0d rdy=%b res=%h, required 1 %0d 1 %b %h",
                         i, ok, g, lw, rdy, res, i, 4'(1 << i), exp_res[i]);
            end
        end
`ifdef FADD_ARB_STATS_EN
        // With this model each transaction spends m_lat+1 = 4 cycles in S_WAIT.
        checks++;
        if (stat_grants !== 32'd4 || stat_wait_cycles !== 32'd16) begin
            errors++;
            $display("FAIL stats: grants=%0d wait=%0d, required 4 16", stat_grants, stat_wait_cycles);
        end
`endif
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_g [3]   = '{2'd2, 2'd0, 2'd2};
        logic [31:0] exp_res [3] = '{32'h2022, 32'h0505, 32'h2022};
        logic [3:0]  clr [3]     = '{4'b0000, 4'b0001, 4'b0100};
        bit ok; logic [1:0] g; int lw; logic [3:0] rdy; logic [31:0] res;
        req_a[95:64] = 32'h2000; req_b[95:64] = 32'h22;
        req_a[31:0]  = 32'h0500; req_b[31:0]  = 32'h05;
        req_stb = 4'b0100;
        wait_load(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fair_first_load: timeout, required a load");
        end
        req_stb = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            do_txn(clr[i], ok, g, lw, rdy, res);
            checks++;
            if (!ok || g !== exp_g[i] || rdy !== 4'(1 << exp_g[i]) || res !== exp_res[i]) begin
                errors++;
                $display("FAIL fair_txn%0d: ok=%b g=%0d rdy=%b res=%h, required 1 %0d %h",
                         i, ok, g, rdy, res, exp_g[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_reset_midwait();
        bit ok; logic [1:0] g; int lw; logic [3:0] rdy; logic [31:0] res;
        m_lat = 20;
        req_a[63:32] = 32'hDEAD0000; req_b[63:32] = 32'h0000BEEF;
        req_stb = 4'b0010;
        wait_load(ok);
        checks++;
        if (!ok || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL midwait_grant: ok=%b g=%0d, required 1 1", ok, grant_idx);
        end
        req_stb = '0;
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rsp_ready, rsp_result, adder_load, adder_ack, adder_a, adder_b, grant_idx, busy} !== '0) begin
            errors++;
            $display("FAIL midwait_async_reset: rdy=%b res=%h load=%b ack=%b a=%h b=%h g=%0d busy=%b, required all 0",
                     rsp_ready, rsp_result, adder_load, adder_ack, adder_a, adder_b, grant_idx, busy);
        end
        tick();
        reset = 1'b1;
        m_lat = 3;
        tick(); tick(); tick();
        checks++;
        if (rsp_ready !== 4'b0000 || busy !== 1'b0 || rsp_result !== 32'h0) begin
            errors++;
            $display("FAIL midwait_no_stale: rdy=%b busy=%b res=%h, required 0000 0 0", rsp_ready, busy, rsp_result);
        end
        req_a[63:32]   = 32'h11; req_b[63:32]   = 32'h22;
        req_a[127:96]  = 32'h44; req_b[127:96]  = 32'h55;
        req_stb = 4'b1010;
        do_txn(4'b0010, ok, g, lw, rdy, res);
        checks++;
        if (!ok || g !== 2'd1 || rdy !== 4'b0010 || res !== 32'h33) begin
            errors++;
            $display("FAIL midwait_regrant: ok=%b g=%0d rdy=%b res=%h, required 1 1 0010 00000033", ok, g, rdy, res);
        end
        do_txn(4'b1000, ok, g, lw, rdy, res);
        checks++;
        if (!ok || g !== 2'd3 || rdy !== 4'b1000 || res !== 32'h99) begin
            errors++;
            $display("FAIL midwait_second: ok=%b g=%0d rdy=%b res=%h, required 1 3 1000 00000099", ok, g, rdy, res);
        end
    endtask

    task automatic test_release_hold();
        bit ok; logic [1:0] g; int lw; logic [3:0] rdy; logic [31:0] res;
        int t, bad;
        m_hold = 3;
        req_a[31:0]  = 32'h7;  req_b[31:0]  = 32'h8;
        req_a[63:32] = 32'h70; req_b[63:32] = 32'h80;
        req_stb = 4'b0011;
        do_txn(4'b0001, ok, g, lw, rdy, res);
        checks++;
        if (!ok || g !== 2'd0 || res !== 32'hF) begin
            errors++;
            $display("FAIL hold_first: ok=%b g=%0d res=%h, required 1 0 0000000f", ok, g, res);
        end
        t = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            t++;
            if (adder_load && adder_ready) bad++;
            if (!adder_load && busy !== 1'b1 && adder_ready) bad++;
            if (adder_load) break;
        end
        // Ready lingers 3 cycles past the ack, then S_RELEASE exit and the grant take one each.
        checks++;
        if (t !== 5 || bad !== 0) begin
            errors++;
            $display("FAIL hold_next_load: cycles=%0d overlap=%0d, required 5 0", t, bad);
        end
        do_txn(4'b0010, ok, g, lw, rdy, res);
        checks++;
        if (!ok || g !== 2'd1 || lw !== 1 || res !== 32'hF0) begin
            errors++;
            $display("FAIL hold_second: ok=%b g=%0d loadw=%0d res=%h, required 1 1 1 000000f0", ok, g, lw, res);
        end
        m_hold = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_midwait();
        test_release_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/fadd_share_arbiter.md
Name: fadd_share_arbiter

Overview:
- Round-robin arbiter sharing one floating-point `adder` instance (load / Number1 / Number2 / result_ready / result_ack / Result handshake) among N_REQ requesters, e.g. several tbt_adder-style matrix sequencers.
- Sits between the requesters and the adder instance.
- Serialises one 32-bit add per grant and returns the sum to the granted requester through a ready/ack handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must be ≥ clog2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_stb  input  N_REQ  per-requester request; level, held until served.
- req_a  input  32*N_REQ  operand A of requester i at [i*32+:32].
- req_b  input  32*N_REQ  operand B of requester i at [i*32+:32].
- rsp_ready  output  N_REQ  one-hot result-valid to the granted requester.
- rsp_result  output  32  sum of the current transaction, shared bus.
- rsp_ack  input  N_REQ  requester acknowledges its result.
- grant_idx  output  IDX_W  index of the current or last grant.
- busy  output  1  high in any state other than S_IDLE.
- adder_load  output  1  to adder `load`.
- adder_a  output  32  to adder Number1.
- adder_b  output  32  to adder Number2.
- adder_ready  input  1  from adder `result_ready`.
- adder_result  input  32  from adder `Result`.
- adder_ack  output  1  to adder `result_ack`.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-transaction):
  - state = S_IDLE.
  - rsp_ready = 0, rsp_result = 0, adder_load = 0, adder_ack = 0, adder_a = 0, adder_b = 0.
  - grant_idx = 0, busy = 0.
  - Round-robin pointer rr_ptr = 0.
- States: S_IDLE, S_WAIT, S_DELIVER, S_RELEASE.
- S_IDLE:
  - If any req_stb is set, grant the first set bit searching from rr_ptr upward, with wrap-around modulo N_REQ.
  - Same edge: latch grant_idx and the granted operands into adder_a / adder_b, set adder_load = 1, rr_ptr = grant + 1 mod N_REQ, go to S_WAIT.
  - If no req_stb is set, stay in S_IDLE.
- S_WAIT:
  - adder_load is forced to 0, so load is exactly a one-cycle pulse.
  - When adder_ready = 1: capture adder_result into rsp_result, set rsp_ready[grant_idx] = 1 and adder_ack = 1, go to S_DELIVER.
- S_DELIVER:
  - Hold rsp_ready, rsp_result and adder_ack.
  - On rsp_ack[grant_idx] = 1: clear rsp_ready and adder_ack, go to S_RELEASE.
  - rsp_ack on any other bit is ignored.
- S_RELEASE:
  - Wait until adder_ready = 0, then go to S_IDLE.
  - This prevents a stale ready from being read as the next result.
- Latency:
  - req_stb → adder_load: 1 cycle.
  - adder_ready → rsp_ready: 1 cycle.
  - rsp_ack → next adder_load: at least 2 cycles (S_RELEASE, then S_IDLE grant).
- Requester rules:
  - A requester deasserts req_stb no later than the cycle it asserts rsp_ack.
  - Operands are sampled only at grant; changes afterwards are ignored.
  - If req_stb drops during S_WAIT, the transaction still completes and the result is still delivered.
- Fairness:
  - The just-served requester has lowest priority at the next grant, so one requester holding req_stb cannot starve the others.
  - Worst-case wait is N_REQ-1 transactions.
- rsp_result keeps the last sum until the next capture.
- busy = 1 in every state except S_IDLE.
- Simultaneous requests: only one grant per S_IDLE visit; the others stay pending.

Optional Feature:
- Macro: FADD_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants (32 bits): count of completed transactions, incremented on rsp_ack acceptance.
  - Adds output stat_wait_cycles (32 bits): count of cycles spent in S_WAIT.
  - Both reset to 0 and wrap at 2^32.
- When undefined:
  - Ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Single request, requester 0: a = 0x3F800000 (1.0), b = 0x40000000 (2.0); adder model replies 3 cycles after load.
   → one-cycle adder_load; rsp_result = 0x40400000; rsp_ready = 0b0001; after rsp_ack, adder_ack drops and busy drops 2 cycles later.
2. All four req_stb asserted together at reset state.
   → grant order 0, 1, 2, 3, each with a single load pulse; each rsp_ready is one-hot on the correct bit.
3. Requester 2 holds req_stb continuously and requester 0 asserts once.
   → grants alternate 2, 0, 2; requester 0 is served within one transaction.
4. Reset asserted during S_WAIT (adder_ready pending).
   → all outputs 0 immediately; after release, a new request is granted from index 0 and the old result is never delivered.
5. Adder model holds adder_ready for 3 cycles after adder_ack.
   → arbiter stays in S_RELEASE; no new adder_load until adder_ready is 0.
6. With FADD_ARB_STATS_EN: run scenario 2 with 3-cycle adder latency.
   → stat_grants = 4; stat_wait_cycles = 12 (±1 cycle per transaction, per the model's ready timing).
